lsb: RTL and testbench

Load/store buffer: an in-order circular queue of memory operations between the decoder (issue side) and the memory controller. It sits directly upstream of the ROB. It captures address and data operands from the RS and its own result broadcasts, performs loads as soon as operands are ready, and performs stores only when the entry is at the ROB head. Each result is reported to the ROB and RS through a one-cycle broadcast (`lsb_has_output`, `lsb_rob_id`, `lsb_output`).

---
 rtl/lsb.sv | 212 +++++++++++++++++++++
 tb/tb_lsb.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb.sv
// Load/store buffer: in-order ring of memory ops between issue and the memory controller.
// Loads launch once their base is known; stores also wait for the ROB head.
module lsb #(
    parameter int unsigned LSB_SIZE = 8,
    parameter int unsigned ROB_W    = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,

    input  logic             is_ins,
    input  logic             ins_is_store,
    input  logic [2:0]       ins_funct3,
    input  logic [ROB_W-1:0] ins_rob_id,
    input  logic [31:0]      ins_imm,
    input  logic             ins_qj_has,
    input  logic             ins_qk_has,
    input  logic [ROB_W-1:0] ins_qj,
    input  logic [ROB_W-1:0] ins_qk,
    input  logic [31:0]      ins_vj,
    input  logic [31:0]      ins_vk,
    output logic             lsb_full,

    input  logic             rs_has_output,
    input  logic [ROB_W-1:0] rs_rob_id,
    input  logic [31:0]      rs_output,

    input  logic [ROB_W-1:0] rob_head_id,

    output logic             lsb_has_output,
    output logic [ROB_W-1:0] lsb_rob_id,
    output logic [31:0]      lsb_output,

    output logic             mem_req,
    output logic             mem_wr,
    output logic [1:0]       mem_len,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata
);

    localparam int unsigned PtrW = $clog2(LSB_SIZE);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull   = CntW'(LSB_SIZE);
    localparam logic [CntW-1:0] CntAlmost = CntW'(LSB_SIZE - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    logic [LSB_SIZE-1:0] valid_q;
    logic [LSB_SIZE-1:0] is_store_q;
    logic [LSB_SIZE-1:0] qj_has_q;
    logic [LSB_SIZE-1:0] qk_has_q;
    logic [2:0]          funct3_q [LSB_SIZE];
    logic [ROB_W-1:0]    rob_id_q [LSB_SIZE];
    logic [ROB_W-1:0]    qj_q     [LSB_SIZE];
    logic [ROB_W-1:0]    qk_q     [LSB_SIZE];
    logic [31:0]         imm_q    [LSB_SIZE];
    logic [31:0]         vj_q     [LSB_SIZE];
    logic [31:0]         vk_q     [LSB_SIZE];

    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;
    state_e          state_q;

    logic        issue_ok;
    logic        deq;
    logic        head_ready;
    logic [31:0] load_val;
    logic [32:0] ins_j_res;
    logic [32:0] ins_k_res;

    // Returns {still_pending, value} after snooping both result broadcasts.
    function automatic logic [32:0] snoop(input logic has, input logic [ROB_W-1:0] q,
                                          input logic [31:0] v);
        if (has && rs_has_output && rs_rob_id == q) begin
            return {1'b0, rs_output};
        end
        if (has && lsb_has_output && lsb_rob_id == q) begin
            return {1'b0, lsb_output};
        end
        return {has, v};
    endfunction

    assign lsb_full  = (count_q >= CntAlmost);
    assign issue_ok  = is_ins && (count_q != CntFull);
    assign deq       = (state_q == StBusy) && mem_done;
    assign ins_j_res = snoop(ins_qj_has, ins_qj, ins_vj);
    assign ins_k_res = snoop(ins_qk_has, ins_qk, ins_vk);

    always_comb begin
        head_ready = valid_q[head_q] && !qj_has_q[head_q];
        if (is_store_q[head_q]) begin
            head_ready = head_ready && !qk_has_q[head_q] && (rob_head_id == rob_id_q[head_q]);
        end
    end

    always_comb begin
        load_val = mem_rdata;
        case (funct3_q[head_q])
            3'b000:  load_val = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  load_val = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b100:  load_val = {24'b0, mem_rdata[7:0]};
            3'b101:  load_val = {16'b0, mem_rdata[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // Queue storage, pointers and operand capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q    <= '0;
            is_store_q <= '0;
            qj_has_q   <= '0;
            qk_has_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < LSB_SIZE; i++) begin
                funct3_q[i] <= '0;
                rob_id_q[i] <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                imm_q[i]    <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
            end
        end else if (rdy_in) begin
            if (rob_clear) begin
                valid_q <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                for (int i = 0; i < LSB_SIZE; i++) begin
                    if (valid_q[i]) begin
                        {qj_has_q[i], vj_q[i]} <= snoop(qj_has_q[i], qj_q[i], vj_q[i]);
                        {qk_has_q[i], vk_q[i]} <= snoop(qk_has_q[i], qk_q[i], vk_q[i]);
                    end
                end
                if (deq) begin
                    valid_q[head_q] <= 1'b0;
                    head_q          <= head_q + 1'b1;
                end
                if (issue_ok) begin
                    valid_q[tail_q]    <= 1'b1;
                    is_store_q[tail_q] <= ins_is_store;
                    funct3_q[tail_q]   <= ins_funct3;
                    rob_id_q[tail_q]   <= ins_rob_id;
                    imm_q[tail_q]      <= ins_imm;
                    qj_q[tail_q]       <= ins_qj;
                    qk_q[tail_q]       <= ins_qk;
                    {qj_has_q[tail_q], vj_q[tail_q]} <= ins_j_res;
                    {qk_has_q[tail_q], vk_q[tail_q]} <= ins_k_res;
                    tail_q             <= tail_q + 1'b1;
                end
                count_q <= count_q + CntW'(issue_ok) - CntW'(deq);
            end
        end
    end

    // Memory handshake FSM with registered request and broadcast outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= StIdle;
            mem_req        <= 1'b0;
            mem_wr         <= 1'b0;
            mem_len        <= '0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            lsb_has_output <= 1'b0;
            lsb_rob_id     <= '0;
            lsb_output     <= '0;
        end else if (rdy_in) begin
            lsb_has_output <= 1'b0;
            if (rob_clear) begin
                state_q <= StIdle;
                mem_req <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (head_ready) begin
                            state_q   <= StBusy;
                            mem_req   <= 1'b1;
                            mem_wr    <= is_store_q[head_q];
                            mem_len   <= funct3_q[head_q][1:0];
                            mem_addr  <= vj_q[head_q] + imm_q[head_q];
                            mem_wdata <= vk_q[head_q];
                        end
                    end
                    StBusy: begin
                        if (mem_done) begin
                            state_q        <= StIdle;
                            mem_req        <= 1'b0;
                            lsb_has_output <= 1'b1;
                            lsb_rob_id     <= rob_id_q[head_q];
                            lsb_output     <= is_store_q[head_q] ? 32'b0 : load_val;
                        end
                    end
                endcase
            end
        end
    end

    // The decoder must respect lsb_full; an issue into a completely full ring is dropped.
    assert property (@(posedge clk_in) disable iff (rst_in)
                     !(rdy_in && !rob_clear && is_ins && count_q == CntFull))
        else $error("lsb: issue into full queue dropped");

endmodule

// File: tb/tb_lsb.sv
// Directed bench for lsb: table of load vectors plus hand sequences for
// stores, forwarding, full flag, flush and asynchronous reset.
module tb_lsb;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        is_ins;
    logic        ins_is_store;
    logic [2:0]  ins_funct3;
    logic [3:0]  ins_rob_id;
    logic [31:0] ins_imm;
    logic        ins_qj_has;
    logic        ins_qk_has;
    logic [3:0]  ins_qj;
    logic [3:0]  ins_qk;
    logic [31:0] ins_vj;
    logic [31:0] ins_vk;
    logic        lsb_full;
    logic        rs_has_output;
    logic [3:0]  rs_rob_id;
    logic [31:0] rs_output;
    logic [3:0]  rob_head_id;
    logic        lsb_has_output;
    logic [3:0]  lsb_rob_id;
    logic [31:0] lsb_output;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    lsb #(.LSB_SIZE(8), .ROB_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
        .is_ins(is_ins), .ins_is_store(ins_is_store), .ins_funct3(ins_funct3),
        .ins_rob_id(ins_rob_id), .ins_imm(ins_imm), .ins_qj_has(ins_qj_has),
        .ins_qk_has(ins_qk_has), .ins_qj(ins_qj), .ins_qk(ins_qk), .ins_vj(ins_vj),
        .ins_vk(ins_vk), .lsb_full(lsb_full), .rs_has_output(rs_has_output),
        .rs_rob_id(rs_rob_id), .rs_output(rs_output), .rob_head_id(rob_head_id),
        .lsb_has_output(lsb_has_output), .lsb_rob_id(lsb_rob_id), .lsb_output(lsb_output),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] vj;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [1:0]  exp_len;
        logic [31:0] exp_out;
    } lvec_t;

    lvec_t vec [7];
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [3:0] rob,
                         input logic [31:0] imm, input logic qjh, input logic [3:0] qj,
                         input logic [31:0] vj, input logic [31:0] vk);
        is_ins       = 1'b1;
        ins_is_store = st;
        ins_funct3   = f3;
        ins_rob_id   = rob;
        ins_imm      = imm;
        ins_qj_has   = qjh;
        ins_qj       = qj;
        ins_vj       = vj;
        ins_qk_has   = 1'b0;
        ins_qk       = 4'd0;
        ins_vk       = vk;
        tick();
        is_ins     = 1'b0;
        ins_qj_has = 1'b0;
    endtask

    // Completes the in-flight access and checks the following one-cycle broadcast.
    task automatic complete(input string name, input logic [31:0] rdata,
                            input logic [3:0] rob, input logic [31:0] exp_out);
        mem_done  = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        check({name, "_bc_valid"}, lsb_has_output, 1);
        check({name, "_bc_id"}, lsb_rob_id, rob);
        check({name, "_bc_val"}, lsb_output, exp_out);
        check({name, "_req_drop"}, mem_req, 0);
        tick();
        check({name, "_bc_one_cycle"}, lsb_has_output, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; is_ins = 1'b0;
        ins_is_store = 1'b0; ins_funct3 = 3'd0; ins_rob_id = 4'd0; ins_imm = 32'd0;
        ins_qj_has = 1'b0; ins_qk_has = 1'b0; ins_qj = 4'd0; ins_qk = 4'd0;
        ins_vj = 32'd0; ins_vk = 32'd0; rs_has_output = 1'b0; rs_rob_id = 4'd0;
        rs_output = 32'd0; rob_head_id = 4'd0; mem_done = 1'b0; mem_rdata = 32'd0;

        vec[0] = '{3'b010, 32'h0000_0100, 32'h0000_0004, 32'h8000_00F0, 32'h0000_0104, 2'd2,
                   32'h8000_00F0};
        vec[1] = '{3'b000, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_0FFF, 2'd0,
                   32'hFFFF_FFF0};
        vec[2] = '{3'b100, 32'h0000_1000, 32'h0000_0001, 32'h0000_00F0, 32'h0000_1001, 2'd0,
                   32'h0000_00F0};
        vec[3] = '{3'b001, 32'h0000_2000, 32'h0000_0002, 32'h1234_8001, 32'h0000_2002, 2'd1,
                   32'hFFFF_8001};
        vec[4] = '{3'b101, 32'h0000_2000, 32'h0000_0000, 32'h1234_8001, 32'h0000_2000, 2'd1,
                   32'h0000_8001};
        vec[5] = '{3'b001, 32'h0000_3000, 32'h0000_0010, 32'h0000_7FFF, 32'h0000_3010, 2'd1,
                   32'h0000_7FFF};
        vec[6] = '{3'b010, 32'hFFFF_FFFC, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0004, 2'd2,
                   32'hCAFE_F00D};

        #12;
        check("rst_full", lsb_full, 0);
        check("rst_bc_valid", lsb_has_output, 0);
        check("rst_bc_id", lsb_rob_id, 0);
        check("rst_bc_val", lsb_output, 0);
        check("rst_req", mem_req, 0);
        check("rst_wr", mem_wr, 0);
        check("rst_len", mem_len, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_in = 1'b0;
        tick();

        // Single loads: launch latency, request hold, extension of the returned data.
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, vec[i].f3, 4'(i + 1), vec[i].imm, 1'b0, 4'd0, vec[i].vj, 32'd0);
            check($sformatf("vec%0d_req_early", i), mem_req, 0);
            tick();
            check($sformatf("vec%0d_req", i), mem_req, 1);
            check($sformatf("vec%0d_wr", i), mem_wr, 0);
            check($sformatf("vec%0d_addr", i), mem_addr, vec[i].exp_addr);
            check($sformatf("vec%0d_len", i), mem_len, vec[i].exp_len);
            tick();
            tick();
            check($sformatf("vec%0d_req_hold", i), mem_req, 1);
            check($sformatf("vec%0d_addr_hold", i), mem_addr, vec[i].exp_addr);
            complete($sformatf("vec%0d", i), vec[i].rdata, 4'(i + 1), vec[i].exp_out);
        end

        // LB then LBU back to back: order preserved, next launch one cycle after done.
        issue(1'b0, 3'b000, 4'd1, 32'd0, 1'b0, 4'd0, 32'h300, 32'd0);
        issue(1'b0, 3'b100, 4'd2, 32'd0, 1'b0, 4'd0, 32'h304, 32'd0);
        check("order_first_req", mem_req, 1);
        check("order_first_addr", mem_addr, 32'h300);
        mem_done = 1'b1; mem_rdata = 32'hF0;
        tick();
        mem_done = 1'b0;
        check("order_lb_val", lsb_output, 32'hFFFF_FFF0);
        check("order_lb_id", lsb_rob_id, 1);
        tick();
        check("order_second_req", mem_req, 1);
        check("order_second_addr", mem_addr, 32'h304);
        complete("order_lbu", 32'hF0, 4'd2, 32'h0000_00F0);

        // Store waits for the ROB head.
        rob_head_id = 4'd0;
        issue(1'b1, 3'b010, 4'd3, 32'h8, 1'b0, 4'd0, 32'h400, 32'hDEAD_BEEF);
        tick();
        check("st_wait0", mem_req, 0);
        tick();
        check("st_wait1", mem_req, 0);
        rob_head_id = 4'd3;
        tick();
        check("st_req", mem_req, 1);
        check("st_wr", mem_wr, 1);
        check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_addr", mem_addr, 32'h408);
        check("st_len", mem_len, 2);
        complete("st", 32'h1234_5678, 4'd3, 32'd0);
        rob_head_id = 4'd0;

        // Base operand from the RS broadcast, a wrong id first.
        issue(1'b0, 3'b010, 4'd6, 32'h10, 1'b1, 4'd5, 32'd0, 32'd0);
        rs_has_output = 1'b1; rs_rob_id = 4'd4; rs_output = 32'h999;
        tick();
        rs_has_output = 1'b0;
        tick();
        check("fwd_rs_wrong_id", mem_req, 0);
        rs_has_output = 1'b1; rs_rob_id = 4'd5; rs_output = 32'h200;
        tick();
        rs_has_output = 1'b0;
        check("fwd_rs_capture_edge", mem_req, 0);
        tick();
        check("fwd_rs_req", mem_req, 1);
        check("fwd_rs_addr", mem_addr, 32'h210);
        complete("fwd_rs", 32'h1, 4'd6, 32'h1);

        // RS broadcast in the same cycle as the issue; then a rdy_in stall on mem_done.
        rs_has_output = 1'b1; rs_rob_id = 4'd5; rs_output = 32'h300;
        issue(1'b0, 3'b010, 4'd6, 32'h20, 1'b1, 4'd5, 32'd0, 32'd0);
        rs_has_output = 1'b0;
        check("fwd_same_early", mem_req, 0);
        tick();
        check("fwd_same_req", mem_req, 1);
        check("fwd_same_addr", mem_addr, 32'h320);
        rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'h55;
        tick();
        tick();
        check("stall_req_held", mem_req, 1);
        check("stall_no_bc", lsb_has_output, 0);
        rdy_in = 1'b1;
        complete("stall", 32'h55, 4'd6, 32'h55);

        // Base operand from the LSB's own broadcast.
        issue(1'b0, 3'b010, 4'd1, 32'd0, 1'b0, 4'd0, 32'h500, 32'd0);
        issue(1'b0, 3'b010, 4'd2, 32'h4, 1'b1, 4'd1, 32'd0, 32'd0);
        check("fwd_lsb_first_addr", mem_addr, 32'h500);
        mem_done = 1'b1; mem_rdata = 32'h600;
        tick();
        mem_done = 1'b0;
        check("fwd_lsb_bc_val", lsb_output, 32'h600);
        tick();
        check("fwd_lsb_wait", mem_req, 0);
        tick();
        check("fwd_lsb_req", mem_req, 1);
        check("fwd_lsb_addr", mem_addr, 32'h604);
        complete("fwd_lsb", 32'h7, 4'd2, 32'h7);

        // Almost-full flag, then a flush while busy with mem_done in the same cycle.
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, 3'b010, 4'(8 + i), 32'(i * 4), 1'b1, 4'd15, 32'd0, 32'd0);
            if (i == 5) check("full_at6", lsb_full, 0);
        end
        check("full_at7", lsb_full, 1);
        rs_has_output = 1'b1; rs_rob_id = 4'd15; rs_output = 32'h700;
        tick();
        rs_has_output = 1'b0;
        tick();
        check("full_head_addr", mem_addr, 32'h700);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("full_bc_id", lsb_rob_id, 8);
        check("full_after_done", lsb_full, 0);
        tick();
        check("full_next_req", mem_req, 1);
        check("full_next_addr", mem_addr, 32'h704);
        rob_clear = 1'b1; mem_done = 1'b1;
        tick();
        rob_clear = 1'b0; mem_done = 1'b0;
        check("clr_req", mem_req, 0);
        check("clr_no_bc", lsb_has_output, 0);
        check("clr_full", lsb_full, 0);
        tick();
        tick();
        check("clr_no_stale", mem_req, 0);
        issue(1'b0, 3'b010, 4'd7, 32'd0, 1'b0, 4'd0, 32'h800, 32'd0);
        tick();
        check("clr_new_req", mem_req, 1);
        check("clr_new_addr", mem_addr, 32'h800);
        complete("clr_new", 32'h42, 4'd7, 32'h42);

        // Asynchronous reset between clock edges while busy.
        issue(1'b0, 3'b010, 4'd9, 32'd0, 1'b0, 4'd0, 32'h900, 32'd0);
        tick();
        check("ar_req_before", mem_req, 1);
        #3;
        rst_in = 1'b1;
        #1;
        check("ar_req_now", mem_req, 0);
        check("ar_addr_now", mem_addr, 0);
        check("ar_bc_now", lsb_has_output, 0);
        #2;
        rst_in = 1'b0;
        tick();
        tick();
        check("ar_empty", mem_req, 0);
        issue(1'b0, 3'b010, 4'd10, 32'h4, 1'b0, 4'd0, 32'hA00, 32'd0);
        tick();
        check("ar_new_addr", mem_addr, 32'hA04);
        complete("ar_new", 32'h99, 4'd10, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
